branch_hazard_stall_ctrl: RTL
=============================

// Module: branch_hazard_stall_ctrl
// PURPOSE
//  Consumer side of the ID-stage branch forwarding detector: takes its th1/th2 match flags plus producer type.
//  Decides how many cycles a branch (op 3'b110) in ID must wait before its operands can be forwarded.
//  Drives PC / IF-ID hold and ID-EX bubble insertion, and keeps stall/hazard perf counters.
//  Sits in the hazard unit between the ID forwarding detector and the pipeline-register enables.
// PARAMETERS
//  CNT_W           32  width of perf counters stall_cycles / hazard_events
//  ALU_EX_STALL    1   stall cycles when producer is an ALU op in EX (th1 & !memread_EX)
//  LOAD_EX_STALL   2   stall cycles when producer is a load in EX (th1 & memread_EX)
//  LOAD_MEM_STALL  1   stall cycles when producer is a load in MEM (th2 & memread_MEM)
//  All three stall parameters are legal in 0..3; the remaining-cycle counter is 2 bits.
// PORTS
//  clk            in   1      pipeline clock
//  rst            in   1      synchronous, active-high reset
//  valid_ID       in   1      ID holds a real instruction (not a bubble)
//  op             in   3      ID opcode class; branch = OP_BRANCH (3'b110)
//  th1            in   1      ID source matches rd_EX (from ID forwarding detector)
//  th2            in   1      ID source matches rd_MEM (from ID forwarding detector)
//  memread_EX     in   1      instruction in EX is a load
//  memread_MEM    in   1      instruction in MEM is a load
//  flush          in   1      redirect/kill of the ID instruction (taken branch, trap)
//  pc_write       out  1      PC update enable (0 = hold)
//  ifid_write     out  1      IF/ID register enable (0 = hold)
//  idex_bubble    out  1      1 = load NOP into ID/EX this cycle
//  stall_active   out  1      1 while any stall cycle is being issued
//  stall_cycles   out  CNT_W  saturating count of stall cycles issued
//  hazard_events  out  CNT_W  saturating count of hazards that caused >=1 stall cycle
// BEHAVIOUR
//  States: IDLE, STALL. Register rem[1:0] holds the stall cycles left after the current one.
//  Hazard needs N cycles (IDLE only; requires valid_ID & op==OP_BRANCH & !flush):
//   th1 & memread_EX -> N = LOAD_EX_STALL; th1 & !memread_EX -> N = ALU_EX_STALL.
//   else th2 & memread_MEM -> N = LOAD_MEM_STALL; otherwise N = 0.
//   th1 has priority over th2, matching the detector's priority.
//  Stall cycle outputs: pc_write=0, ifid_write=0, idex_bubble=1, stall_active=1.
//  Idle outputs: pc_write=1, ifid_write=1, idex_bubble=0, stall_active=0.
//  IDLE with N>0: stall outputs in the same cycle (Mealy, zero latency).
//   Counters: hazard_events+=1 and stall_cycles+=1.
//   If N>1: rem<=N-1 and next state STALL. Otherwise stay in IDLE.
//  STALL: stall outputs and stall_cycles+=1. th1/th2 are ignored, because the bubble is moving down the pipe.
//   If rem==1: go to IDLE. Otherwise rem<=rem-1.
//  IDLE with N==0: idle outputs; counters are held.
//  flush (any state, highest priority): pc_write=1, ifid_write=1, idex_bubble=1, stall_active=0.
//   Next state IDLE, rem<=0; no counter increment in that cycle.
//  Not valid_ID or op!=OP_BRANCH in IDLE: idle outputs, regardless of th1/th2.
//  Counters saturate at all-ones and never wrap.
//  rst=1: next state IDLE, rem=0, both counters=0. While rst is high, outputs are forced to idle values.
//   Asserting rst mid-stall aborts the stall the same way.
//  After the last stall cycle the branch is re-evaluated in IDLE. A residual hazard (e.g. the load that has moved to MEM) is handled as a new event.
// STRUCTURE
//  Shared package hazard_pkg: OP_BRANCH=3'b110, typedef enum logic {IDLE,STALL} stall_state_t.
//  The package also holds the default stall-cycle localparams.
//  Sub-module sat_counter #(W) instantiated twice for the perf counters. The FSM and output logic stay in this module.
// TESTING
//  Reset: rst=1 for 2 clk -> pc_write=1, ifid_write=1, idex_bubble=0, counters=0.
//  Branch, th1=1, memread_EX=0 -> exactly 1 stall cycle. Then stall_cycles=1, hazard_events=1.
//  Branch, th1=1, memread_EX=1 -> 2 consecutive stall cycles; cycle 2 is issued even with th1=0 and th2=1.
//   Then stall_cycles=2, hazard_events=1.
//  Branch, th2=1: memread_MEM=1 -> 1 stall; memread_MEM=0 -> 0 stalls. op=3'b000 with th1=1 -> 0 stalls.
//  flush in cycle 1 of a load-in-EX stall -> that cycle pc_write=1, idex_bubble=1; next cycle IDLE; stall_cycles=0.
//  CNT_W=4: 16 ALU-in-EX hazards -> stall_cycles and hazard_events hold at 4'hF; no wrap.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_pkg : shared opcode, FSM state type and stall-cycle defaults, rev 1.0
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [2:0] OP_BRANCH = 3'b110;

  localparam logic [1:0] DEF_ALU_EX_STALL   = 2'd1;
  localparam logic [1:0] DEF_LOAD_EX_STALL  = 2'd2;
  localparam logic [1:0] DEF_LOAD_MEM_STALL = 2'd1;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stall_state_t;

  // th1 outranks th2 so the stall count follows the forwarding detector's choice.
  function automatic logic [1:0] stall_need(
    input logic       th1,
    input logic       th2,
    input logic       memread_ex,
    input logic       memread_mem,
    input logic [1:0] alu_ex,
    input logic [1:0] load_ex,
    input logic [1:0] load_mem
  );
    logic [1:0] n;
    n = 2'd0;
    if (th1) begin
      n = memread_ex ? load_ex : alu_ex;
    end else if (th2 && memread_mem) begin
      n = load_mem;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_hazard_stall_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_hazard_stall_ctrl_if : ID hazard inputs and pipeline-enable outputs, rev 1.0
// ---------------------------------------------------------------------------
interface branch_hazard_stall_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             valid_ID;
  logic [2:0]       op;
  logic             th1;
  logic             th2;
  logic             memread_EX;
  logic             memread_MEM;
  logic             flush;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             stall_active;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] hazard_events;

  modport master (
    output valid_ID, op, th1, th2, memread_EX, memread_MEM, flush,
    input  pc_write, ifid_write, idex_bubble, stall_active,
    input  stall_cycles, hazard_events
  );

  modport slave (
    input  valid_ID, op, th1, th2, memread_EX, memread_MEM, flush,
    output pc_write, ifid_write, idex_bubble, stall_active,
    output stall_cycles, hazard_events
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : W-bit up-counter that sticks at all-ones, rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/branch_hazard_stall_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_hazard_stall_ctrl : holds PC/IF-ID and bubbles ID-EX for branch operand hazards, rev 1.0
// ---------------------------------------------------------------------------
module branch_hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int         CNT_W          = 32,
  parameter logic [1:0] ALU_EX_STALL   = DEF_ALU_EX_STALL,
  parameter logic [1:0] LOAD_EX_STALL  = DEF_LOAD_EX_STALL,
  parameter logic [1:0] LOAD_MEM_STALL = DEF_LOAD_MEM_STALL
) (
  input  logic                      clk,
  input  logic                      rst,
  branch_hazard_stall_ctrl_if.slave bus
);

  stall_state_t     r_state;
  logic [1:0]       r_rem;

  logic [1:0]       w_need;
  logic             w_branch;
  logic             w_new_hazard;
  logic             w_stall;
  logic [CNT_W-1:0] w_stall_cnt;
  logic [CNT_W-1:0] w_hazard_cnt;

  always_comb begin
    w_need       = stall_need(bus.th1, bus.th2, bus.memread_EX, bus.memread_MEM,
                              ALU_EX_STALL, LOAD_EX_STALL, LOAD_MEM_STALL);
    w_branch     = bus.valid_ID && (bus.op == OP_BRANCH) && !bus.flush;
    w_new_hazard = !rst && (r_state == IDLE) && w_branch && (w_need != 2'd0);
    // Once in STALL the bubble is already travelling, so th1/th2 no longer matter.
    w_stall      = w_new_hazard || (!rst && !bus.flush && (r_state == STALL));
  end

  assign bus.pc_write     = !w_stall;
  assign bus.ifid_write   = !w_stall;
  assign bus.idex_bubble  = !rst && (bus.flush || w_stall);
  assign bus.stall_active = w_stall;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_state <= IDLE;
      r_rem   <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_new_hazard && (w_need > 2'd1)) begin
            r_state <= STALL;
            r_rem   <= w_need - 2'd1;
          end
        end
        STALL: begin
          if (r_rem <= 2'd1) begin
            r_state <= IDLE;
            r_rem   <= 2'd0;
          end else begin
            r_rem   <= r_rem - 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rem   <= 2'd0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_stall),
    .o_count (w_stall_cnt)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_hazard_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_new_hazard),
    .o_count (w_hazard_cnt)
  );

  assign bus.stall_cycles  = w_stall_cnt;
  assign bus.hazard_events = w_hazard_cnt;

  a_rem_live: assert property (@(posedge clk) disable iff (rst)
    (r_state == STALL) |-> (r_rem != 2'd0));

  a_hold_pair: assert property (@(posedge clk)
    bus.pc_write == bus.ifid_write);

endmodule
`default_nettype wire
